// File: rtl/calc_op_sequencer.sv
// Command sequencer between a host port and a multi-cycle ALU.
// Accepts one command at a time, drives the ALU until it reports done
// or the wait budget runs out, then holds the response until the host
// takes it. It also keeps completed-command and error statistics.
module calc_op_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic           cmd_sel,
  input  logic [79:0]    cmd_a,
  input  logic [79:0]    cmd_b,
  output logic           alu_en,
  output logic [2:0]     alu_app,
  output logic           alu_sel,
  output logic [79:0]    alu_a,
  output logic [79:0]    alu_b,
  input  logic [159:0]   alu_c,
  input  logic           alu_done,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [159:0]   rsp_data,
  output logic           rsp_err,
  output logic [15:0]    stat_ops,
  output logic [7:0]     stat_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic           cmd_ready_d, alu_en_d, alu_sel_d, rsp_valid_d, rsp_err_d;
  logic [2:0]     alu_app_d;
  logic [79:0]    alu_a_d, alu_b_d;
  logic [159:0]   rsp_data_d;
  logic [15:0]    stat_ops_d;
  logic [7:0]     stat_err_d;
  logic           op_ok;

  assign op_ok = (cmd_op == 3'b001) || (cmd_op == 3'b010) || (cmd_op == 3'b011);

  // Next-state and next-output logic; handshake flags are derived from the
  // next state so they are registered alongside it.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    alu_app_d  = alu_app;
    alu_sel_d  = alu_sel;
    alu_a_d    = alu_a;
    alu_b_d    = alu_b;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    stat_ops_d = stat_ops;
    stat_err_d = stat_err;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_app_d = cmd_op;
          alu_sel_d = cmd_sel;
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          if (op_ok) begin
            state_d = EXEC;
            wait_d  = '0;
          end else begin
            state_d    = RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        end
      end
      EXEC: begin
        if (alu_done) begin
          state_d    = RESP;
          rsp_data_d = alu_c;
          rsp_err_d  = 1'b0;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          state_d    = RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d    = IDLE;
          stat_ops_d = stat_ops + 16'd1;
          if (rsp_err && (stat_err != '1))
            stat_err_d = stat_err + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    alu_en_d    = (state_d == EXEC);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      cmd_ready <= 1'b0;
      alu_en    <= 1'b0;
      alu_app   <= '0;
      alu_sel   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      stat_ops  <= '0;
      stat_err  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cmd_ready <= cmd_ready_d;
      alu_en    <= alu_en_d;
      alu_app   <= alu_app_d;
      alu_sel   <= alu_sel_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      stat_ops  <= stat_ops_d;
      stat_err  <= stat_err_d;
    end
  end

endmodule
